x_multdiv_unit: RTL
===================

// Module: x_multdiv_unit
// PURPOSE
//  Iterative signed 32-bit multiply/divide unit in the execute stage, fed by the DX latch outputs.
//  Accepts one op per start pulse and computes the result over multiple cycles.
//  Raises out_stall so the DX latch (wren low) and upstream stages hold while it is busy.
//  Returns the result with a one-cycle out_ready pulse for the XM latch.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; all values below assume 32
//  CNT_WIDTH   6   iteration counter width; must hold DATA_WIDTH
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   synchronous, active-high
//  in_operandA    in   32  multiplicand / dividend (out_data_readRegA of DX)
//  in_operandB    in   32  multiplier / divisor (out_data_readRegB of DX)
//  in_ctrl_MULT   in   1   start signed multiply (one-cycle pulse)
//  in_ctrl_DIV    in   1   start signed divide (one-cycle pulse)
//  out_result     out  32  product low word or quotient
//  out_exception  out  1   overflow or divide-by-zero; valid with out_ready
//  out_ready      out  1   one-cycle completion pulse
//  out_stall      out  1   hold DX latch and upstream; combinational
// BEHAVIOUR
//  Reset (sync, any state, mid-op included)
//   - state <= IDLE, counter <= 0, out_result <= 0, out_exception <= 0, out_ready <= 0.
//   - The in-flight op is discarded and produces no ready pulse.
//  States: IDLE, MULT, DIV, DONE. DONE lasts exactly one cycle and then returns to IDLE.
//  Starting an op
//   - A start is accepted only in IDLE or DONE (back-to-back allowed).
//   - On the start edge k: operand magnitudes, result sign and op type are latched; counter <= 0.
//   - MULT and DIV both high: MULT wins and DIV is ignored.
//   - Start pulses in MULT or DIV are ignored.
//  MULT
//   - Shift-add on magnitudes; one multiplier bit per edge.
//   - Iterations run on edges k+1..k+32. On edge k+32: state <= DONE, out_result <= signed low 32 bits.
//   - out_exception = 1 if the full 64-bit signed product does not fit in a signed 32-bit value.
//  DIV
//   - Restoring division on magnitudes; one quotient bit per edge, edges k+1..k+32.
//   - Quotient truncates toward zero; the remainder is discarded.
//   - Divisor 0: detected at start. Edge k+1 goes to DONE with out_result = 0, out_exception = 1.
//   - 0x80000000 / -1: out_result = 0x80000000, out_exception = 1, full 32-cycle latency.
//  Outputs
//   - out_ready = 1 only in DONE.
//   - out_result and out_exception are held until the next completion or reset.
//   - out_stall = (state in {MULT, DIV}) | (start accepted this cycle). It is low in DONE and IDLE.
// CONFIGURATION
//  MULTDIV_EARLY_EXIT_EN
//   - Defined: MULT finishes on the edge where the right-shifted remaining multiplier magnitude
//     becomes 0 (minimum 1 iteration). The done edge is k + bitlen(|B|), or k+1 when B = 0.
//   - Undefined: MULT always takes 32 iterations.
//   - DIV timing is identical in both builds.
// TESTING
//  1. MULT 7 * -6 at edge k -> out_ready at k+32 only, out_result 0xFFFFFFD6, exc 0, stall high k..k+31.
//  2. MULT 0x00010000 * 0x00010000 -> out_result 0x00000000, exc 1.
//  3. DIV -7 / 2 -> out_result 0xFFFFFFFD, exc 0, ready at k+32.
//     DIV 5 / 0 -> ready at k+1, out_result 0, exc 1.
//  4. Reset at edge k+10 of a MULT -> next cycle ready 0, stall 0, result 0.
//     A new DIV 9/3 then returns 3.
//  5. MULT and DIV pulsed together with 4, 2 -> result 8 (multiply).
//     A MULT pulse at k+5 mid-op is ignored.
//     Back-to-back start in the DONE cycle is accepted.
//  6. MULT 3 * 5: with MULTDIV_EARLY_EXIT_EN, ready at k+3, result 15.
//     Without the macro, ready at k+32, result 15.

Source files
------------

// File: rtl/x_multdiv_unit.sv
`default_nettype none
//==============================================================================
// Module   : x_multdiv_unit
// Brief    : Iterative signed multiply/divide unit for the execute stage.
//            Shift-add multiply and restoring divide on operand magnitudes,
//            one bit per clock.  The DX latch and upstream stages are held
//            through out_stall while an op is in flight.  Completion is a
//            one-cycle out_ready pulse toward the XM latch.
// Config   : MULTDIV_EARLY_EXIT_EN - when defined, a multiply stops as soon
//            as the remaining multiplier magnitude has been consumed.
// Revision : 1.0 - initial release
//==============================================================================
module x_multdiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_operandA,
   input  logic [DATA_WIDTH-1:0] in_operandB,
   input  logic                  in_ctrl_MULT,
   input  logic                  in_ctrl_DIV,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_exception,
   output logic                  out_ready,
   output logic                  out_stall
);

   localparam logic [CNT_WIDTH-1:0]    c_last      = CNT_WIDTH'(DATA_WIDTH - 1);
   // Largest product magnitude that still fits as a negative signed result.
   localparam logic [2*DATA_WIDTH-1:0] c_neg_limit =
      {{DATA_WIDTH{1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [CNT_WIDTH-1:0]    r_cnt;
   logic [2*DATA_WIDTH-1:0] r_opa;      // multiplicand (shifts left) / dividend-quotient in low half
   logic [DATA_WIDTH-1:0]   r_opb;      // multiplier (shifts right) / divisor
   logic [2*DATA_WIDTH-1:0] r_acc;      // product accumulator / partial remainder
   logic                    r_neg;      // result sign
   logic                    r_div_zero;

   logic                    w_accept;
   logic                    w_start_mult;
   logic                    w_start_div;
   logic [DATA_WIDTH-1:0]   w_mag_a;
   logic [DATA_WIDTH-1:0]   w_mag_b;
   logic [2*DATA_WIDTH-1:0] w_mul_sum;
   logic [DATA_WIDTH-1:0]   w_mul_lo;
   logic [DATA_WIDTH-1:0]   w_mul_res;
   logic                    w_mul_ovf;
   logic                    w_mul_last;
   logic [DATA_WIDTH:0]     w_rem_sh;
   logic [DATA_WIDTH:0]     w_diff;
   logic                    w_fits;
   logic [DATA_WIDTH-1:0]   w_quo_next;
   logic [DATA_WIDTH-1:0]   w_quo_res;
   logic                    w_div_ovf;
   logic                    w_div_last;

   // Start acceptance; MULT has priority when both pulses arrive together.
   assign w_accept     = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_start_mult = w_accept & in_ctrl_MULT;
   assign w_start_div  = w_accept & in_ctrl_DIV & ~in_ctrl_MULT;

   assign w_mag_a = in_operandA[DATA_WIDTH-1] ? -in_operandA : in_operandA;
   assign w_mag_b = in_operandB[DATA_WIDTH-1] ? -in_operandB : in_operandB;

   // Multiply step: add the shifted multiplicand when the current multiplier bit is set.
   assign w_mul_sum = r_acc + (r_opb[0] ? r_opa : {(2*DATA_WIDTH){1'b0}});
   assign w_mul_lo  = w_mul_sum[DATA_WIDTH-1:0];
   assign w_mul_res = r_neg ? -w_mul_lo : w_mul_lo;
   assign w_mul_ovf = r_neg ? (w_mul_sum > c_neg_limit)
                            : (|w_mul_sum[2*DATA_WIDTH-1:DATA_WIDTH-1]);

`ifdef MULTDIV_EARLY_EXIT_EN
   // Finish once no set multiplier bits remain beyond the one just consumed.
   assign w_mul_last = (r_opb[DATA_WIDTH-1:1] == '0);
`else
   assign w_mul_last = (r_cnt == c_last);
`endif

   // Restoring divide step: shift in the next dividend bit, subtract if it fits.
   assign w_rem_sh   = {r_acc[DATA_WIDTH-1:0], r_opa[DATA_WIDTH-1]};
   assign w_diff     = w_rem_sh - {1'b0, r_opb};
   assign w_fits     = ~w_diff[DATA_WIDTH];
   assign w_quo_next = {r_opa[DATA_WIDTH-2:0], w_fits};
   assign w_quo_res  = r_neg ? -w_quo_next : w_quo_next;
   assign w_div_ovf  = ~r_neg & w_quo_next[DATA_WIDTH-1];   // only MIN / -1 lands here
   assign w_div_last = (r_cnt == c_last);

   assign out_ready = (r_state == S_DONE);
   assign out_stall = (r_state == S_MULT) || (r_state == S_DIV) || w_start_mult || w_start_div;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start_mult)     w_state_next = S_MULT;
            else if (w_start_div) w_state_next = S_DIV;
            else                  w_state_next = S_IDLE;
         end
         S_MULT:  if (w_mul_last) w_state_next = S_DONE;
         S_DIV:   if (r_div_zero || w_div_last) w_state_next = S_DONE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Operand latch, iteration datapath and held result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt         <= '0;
         out_result    <= '0;
         out_exception <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_mult || w_start_div) begin
                  r_opa      <= {{DATA_WIDTH{1'b0}}, w_mag_a};
                  r_opb      <= w_mag_b;
                  r_acc      <= '0;
                  r_neg      <= in_operandA[DATA_WIDTH-1] ^ in_operandB[DATA_WIDTH-1];
                  r_div_zero <= (in_operandB == '0);
                  r_cnt      <= '0;
               end
            end
            S_MULT: begin
               r_acc <= w_mul_sum;
               r_opa <= r_opa << 1;
               r_opb <= r_opb >> 1;
               r_cnt <= r_cnt + CNT_WIDTH'(1);
               if (w_mul_last) begin
                  out_result    <= w_mul_res;
                  out_exception <= w_mul_ovf;
               end
            end
            S_DIV: begin
               if (r_div_zero) begin
                  out_result    <= '0;
                  out_exception <= 1'b1;
               end else begin
                  r_acc <= {{DATA_WIDTH{1'b0}},
                            w_fits ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0]};
                  r_opa <= {r_opa[2*DATA_WIDTH-1:DATA_WIDTH], w_quo_next};
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
                  if (w_div_last) begin
                     out_result    <= w_quo_res;
                     out_exception <= w_div_ovf;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
